// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle mul, redirect.
// Ports: clock/reset; ID/EX hazard inputs; pipe stall/flush outputs, mul_busy, protocol_err, stall_cycles.
module pipeline_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int RA_W        = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs_addr,
    input  logic [RA_W-1:0] id_rt_addr,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic            ex_valid,
    input  logic            ex_mem_to_reg,
    input  logic [RA_W-1:0] ex_rd_addr,
    input  logic            ex_is_mul,
    input  logic            ex_redirect,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            id_ex_stall,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic            mul_busy,
    output logic            protocol_err,
    output logic [31:0]     stall_cycles
);

    localparam int CW = $clog2(MUL_LATENCY) + 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_LATENCY - 1);
    localparam bit MUL_STALL = (MUL_LATENCY > 1);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] mul_cnt;
    logic [CW-1:0] mul_cnt_nxt;
    logic          perr_set;
    logic          ld_hazard;
    logic          rs_hit;
    logic          rt_hit;

    assign rs_hit = id_uses_rs && (id_rs_addr == ex_rd_addr);
    assign rt_hit = id_uses_rt && (id_rt_addr == ex_rd_addr);
    assign ld_hazard = ex_valid && ex_mem_to_reg && id_valid
                     && (ex_rd_addr != '0) && (rs_hit || rt_hit);

    always_comb begin
        state_nxt    = state;
        mul_cnt_nxt  = mul_cnt;
        perr_set     = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mul_busy     = (state == MUL_WAIT);
        case (state)
            RUN: begin
                if (MUL_STALL && ex_valid && ex_is_mul) begin
                    // Hold front end, bubble into MEM; a redirect here is illegal.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mul_cnt_nxt  = CW'(1);
                    state_nxt    = MUL_WAIT;
                    perr_set     = ex_redirect;
                end else if (ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ld_hazard) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            MUL_WAIT: begin
                if (mul_cnt == LAST) begin
                    // Multiply advances to MEM on this edge.
                    mul_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mul_cnt_nxt  = mul_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt   = RUN;
                mul_cnt_nxt = '0;
            end
        endcase
        // Pipe registers clear themselves in reset; keep control quiet.
        if (reset) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mul_busy     = 1'b0;
            perr_set     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            mul_cnt      <= '0;
            protocol_err <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            if (perr_set) begin
                protocol_err <= 1'b1;
            end
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MUL_LATENCY=4).
// Table of single-cycle decode vectors plus multi-cycle mul/redirect/reset sequences.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_valid;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_rd_addr;
    logic        ex_is_mul;
    logic        ex_redirect;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mul_busy;
    logic        protocol_err;
    logic [31:0] stall_cycles;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(
        .MUL_LATENCY(4),
        .RA_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .id_valid(id_valid),
        .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_rd_addr(ex_rd_addr),
        .ex_is_mul(ex_is_mul),
        .ex_redirect(ex_redirect),
        .pc_stall(pc_stall),
        .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mul_busy(mul_busy),
        .protocol_err(protocol_err),
        .stall_cycles(stall_cycles)
    );

    // Expected bits: {pc, if_id_stall, id_ex_stall, if_id_flush,
    //                 id_ex_flush, ex_mem_flush, mul_busy, protocol_err}
    typedef struct {
        bit         rst;
        bit         idv;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         urs;
        bit         urt;
        bit         exv;
        bit         m2r;
        logic [4:0] rd;
        bit         mul;
        bit         redir;
        logic [7:0] exp;
        string      name;
    } vec_t;

    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LD   = 8'b1100_1000;
    localparam logic [7:0] E_RED  = 8'b0001_1000;
    localparam logic [7:0] E_MUL  = 8'b1110_0100;
    localparam logic [7:0] E_MULW = 8'b1110_0110;
    localparam logic [7:0] E_FREE = 8'b0000_0010;

    logic [7:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned sc_model = 0;

    function automatic vec_t mk(
        input bit rst, input bit idv,
        input logic [4:0] rs, input logic [4:0] rt,
        input bit urs, input bit urt,
        input bit exv, input bit m2r, input logic [4:0] rd,
        input bit mul, input bit redir,
        input logic [7:0] exp, input string name
    );
        vec_t t;
        t.rst = rst;
        t.idv = idv;
        t.rs = rs;
        t.rt = rt;
        t.urs = urs;
        t.urt = urt;
        t.exv = exv;
        t.m2r = m2r;
        t.rd = rd;
        t.mul = mul;
        t.redir = redir;
        t.exp = exp;
        t.name = name;
        return t;
    endfunction

    task automatic cyc(input vec_t t);
        logic [7:0] e;
        logic [7:0] a;
        @(negedge clock);
        reset         = t.rst;
        id_valid      = t.idv;
        id_rs_addr    = t.rs;
        id_rt_addr    = t.rt;
        id_uses_rs    = t.urs;
        id_uses_rt    = t.urt;
        ex_valid      = t.exv;
        ex_mem_to_reg = t.m2r;
        ex_rd_addr    = t.rd;
        ex_is_mul     = t.mul;
        ex_redirect   = t.redir;
        exp_q.push_back(t.exp);
        #2;
        e = exp_q.pop_front();
        a = {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
             id_ex_flush, ex_mem_flush, mul_busy, protocol_err};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: outputs=%b expected=%b", t.name, a, e);
        end
        checks++;
        if (stall_cycles !== sc_model) begin
            errors++;
            $display("FAIL %s stall_cycles: got=%0d expected=%0d",
                     t.name, stall_cycles, sc_model);
        end
        if (t.rst) sc_model = 0;
        else if (e[7]) sc_model++;
    endtask

    vec_t tbl[$];
    vec_t mulv;
    vec_t mulx;

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_valid = 0;
        ex_mem_to_reg = 0; ex_rd_addr = 0; ex_is_mul = 0;
        ex_redirect = 0;
        repeat (2) @(posedge clock);

        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,E_NONE,"reset"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"idle"));
        tbl.push_back(mk(0,1,5,0,1,0,1,1,5,0,0,E_LD,"ld_rs_r5"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"after_ld"));
        tbl.push_back(mk(0,1,0,0,1,1,1,1,0,0,0,E_NONE,"ld_r0"));
        tbl.push_back(mk(0,1,5,0,0,0,1,1,5,0,0,E_NONE,"rs_unused"));
        tbl.push_back(mk(0,1,0,5,0,1,1,1,5,0,0,E_LD,"ld_rt_r5"));
        tbl.push_back(mk(0,0,5,5,1,1,1,1,5,0,0,E_NONE,"id_bubble"));
        tbl.push_back(mk(0,1,5,5,1,1,1,0,5,0,0,E_NONE,"not_load"));
        tbl.push_back(mk(0,1,5,5,1,1,0,1,5,0,0,E_NONE,"ex_bubble"));
        tbl.push_back(mk(0,1,5,0,1,0,1,1,5,0,1,E_RED,"redir_ld"));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,0,0,1,E_RED,"redir"));
        tbl.push_back(mk(0,1,31,3,1,1,1,1,31,0,0,E_LD,"ld_r31"));
        tbl.push_back(mk(0,1,5,7,1,1,1,1,6,0,0,E_NONE,"rd_miss"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,E_NONE,"mul_inval"));
        foreach (tbl[i]) cyc(tbl[i]);

        mulv = mk(0,0,0,0,0,0,1,0,9,1,0,E_MUL,"mul_start");
        mulx = mk(0,1,9,0,1,0,1,1,9,1,1,E_MULW,"mul_wait_ign");

        // Single multiply; hazards and redirects ignored while waiting.
        cyc(mulv);
        cyc(mulx);
        mulx.name = "mul_wait2";
        cyc(mulx);
        mulx.exp = E_FREE;
        mulx.name = "mul_last";
        cyc(mulx);
        cyc(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"post_mul"));

        // Back-to-back multiplies.
        for (int k = 0; k < 2; k++) begin
            mulv.name = "b2b_start";
            cyc(mulv);
            mulv.exp = E_MULW;
            mulv.name = "b2b_wait";
            cyc(mulv);
            cyc(mulv);
            mulv.exp = E_FREE;
            mulv.name = "b2b_free";
            cyc(mulv);
            mulv.exp = E_MUL;
        end
        cyc(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"post_b2b"));

        // Redirect with multiply in RUN: sticky protocol error.
        cyc(mk(0,0,0,0,0,0,1,0,4,1,1,E_MUL,"perr_set"));
        cyc(mk(0,0,0,0,0,0,1,0,4,1,0,E_MULW | 8'h01,"perr_w1"));
        // Reset arrives at cnt=2: outputs quiet, error cleared at edge.
        cyc(mk(1,0,0,0,0,0,1,0,4,1,0,8'b0000_0001,"rst_mid_mul"));
        cyc(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"after_rst"));
        cyc(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"no_residual"));

        // Fresh multiply after reset pays full latency.
        mulv.name = "mul_fresh";
        cyc(mulv);
        mulv.exp = E_MULW;
        cyc(mulv);
        cyc(mulv);
        mulv.exp = E_FREE;
        cyc(mulv);
        cyc(mk(0,0,0,0,0,0,0,0,0,0,0,E_NONE,"final"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
